// File: rtl/dist_uart_reporter.sv
// dist_uart_reporter
//
// Takes a 9-bit distance in centimetres and sends it to a UART transmitter
// as a fixed 7-byte ASCII frame: three decimal digits, "cm", CR, LF
// (for example "123cm\r\n"). Leading zeros are always sent. Values above
// MAX_CM are sent as "---cm\r\n".
//
// The conversion from binary to decimal uses repeated subtraction, one step
// per clock, so no divider is needed. Converting a value takes
// hundreds + tens + 1 cycles.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   dist_cm    distance in cm, sampled only when dist_valid is high
//   dist_valid one-cycle strobe: a new distance is available
//   tx_done    one-cycle pulse from the UART TX: the current byte has been sent
//   tx_start   one-cycle pulse: the UART TX should load tx_data
//   tx_data    ASCII byte, held stable from tx_start until the next byte
//   busy       high while a frame is being converted or sent
//
// A dist_valid that arrives while a frame is in progress is ignored. This
// includes the cycle in which the final tx_done is consumed.

module dist_uart_reporter #(
  parameter int MAX_CM = 400
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] dist_cm,
  input  logic       dist_valid,
  input  logic       tx_done,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    SEND,
    WAIT_DONE
  } state_t;

  // MAX_CM is cut to the width of the distance bus so the range check is a
  // plain 9-bit compare.
  localparam logic [8:0] MAX_CM_V  = 9'(MAX_CM);
  localparam logic [2:0] LAST_BYTE = 3'd6;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_DASH = 8'h2D;
  localparam logic [7:0] ASCII_C    = 8'h63;
  localparam logic [7:0] ASCII_M    = 8'h6D;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  state_t     state;
  logic [8:0] rem;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [2:0] index;
  logic       err;
  logic [7:0] next_byte;

  // Byte table for the frame. The digit positions show dashes when the
  // value was out of range; the digit registers are not looked at then.
  always_comb begin
    next_byte = 8'h00;
    case (index)
      3'd0: next_byte = err ? ASCII_DASH : (ASCII_ZERO + {4'h0, hundreds});
      3'd1: next_byte = err ? ASCII_DASH : (ASCII_ZERO + {4'h0, tens});
      3'd2: next_byte = err ? ASCII_DASH : (ASCII_ZERO + {4'h0, ones});
      3'd3: next_byte = ASCII_C;
      3'd4: next_byte = ASCII_M;
      3'd5: next_byte = ASCII_CR;
      3'd6: next_byte = ASCII_LF;
      default: next_byte = 8'h00;
    endcase
  end

  // Main controller. All outputs are registered here.
  // IDLE accepts a distance. CONV peels off hundreds, then tens, one per
  // clock; whatever remains is the ones digit. SEND presents one byte with a
  // single-cycle tx_start. WAIT_DONE waits for the UART before moving on to
  // the next byte or back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rem      <= 9'd0;
      hundreds <= 4'd0;
      tens     <= 4'd0;
      ones     <= 4'd0;
      index    <= 3'd0;
      err      <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx_start <= 1'b0;
          if (dist_valid) begin
            rem      <= dist_cm;
            hundreds <= 4'd0;
            tens     <= 4'd0;
            ones     <= 4'd0;
            err      <= (dist_cm > MAX_CM_V);
            busy     <= 1'b1;
            state    <= CONV;
          end
        end

        CONV: begin
          // Out-of-range values skip the arithmetic and spend one cycle here.
          if (err) begin
            index <= 3'd0;
            state <= SEND;
          end else if (rem >= 9'd100) begin
            rem      <= rem - 9'd100;
            hundreds <= hundreds + 4'd1;
          end else if (rem >= 9'd10) begin
            rem  <= rem - 9'd10;
            tens <= tens + 4'd1;
          end else begin
            // rem is below 10 here, so its low nibble holds the whole digit.
            ones  <= rem[3:0];
            index <= 3'd0;
            state <= SEND;
          end
        end

        SEND: begin
          tx_data  <= next_byte;
          tx_start <= 1'b1;
          state    <= WAIT_DONE;
        end

        WAIT_DONE: begin
          tx_start <= 1'b0;
          if (tx_done) begin
            if (index == LAST_BYTE) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              index <= index + 3'd1;
              state <= SEND;
            end
          end
        end

        default: begin
          tx_start <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
